// File: rtl/sipo_deframer_if.sv
// Serial-in / parallel-out deframer bus.
// master drives strobes and ack; slave returns word and status.
interface sipo_deframer_if #(
    parameter int WIDTH = 3
);
    localparam int CW = $clog2(WIDTH) + 1;

    logic             shift;
    logic             si;
    logic             ack;
    logic             clr;
    logic [WIDTH-1:0] pout;
    logic             valid;
    logic             busy;
    logic [CW-1:0]    bitcnt;
    logic             overrun;
    logic             frame_err;

    modport master (
        output shift, si, ack, clr,
        input  pout, valid, busy, bitcnt, overrun, frame_err
    );

    modport slave (
        input  shift, si, ack, clr,
        output pout, valid, busy, bitcnt, overrun, frame_err
    );
endinterface

// File: rtl/sipo_deframer.sv
// Reassembles PISO serial bits into WIDTH-bit words with a
// valid/ack output, sticky overrun and stalled-frame timeout.
module sipo_deframer #(
    parameter int WIDTH   = 3,
    parameter int TIMEOUT = 8
) (
    input  logic            clk,
    input  logic            rst,
    sipo_deframer_if.slave  bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] shreg, shreg_n;
    logic [WIDTH-1:0] pout_r, pout_n;
    logic [WIDTH-1:0] word;
    logic [CW-1:0]    cnt, cnt_n;
    logic [7:0]       idle, idle_n;
    logic             valid_r, valid_n;
    logic             ovr, ovr_n;
    logic             ferr, ferr_n;
    logic             done;

    assign word = {bus.si, shreg[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            shreg   <= '0;
            pout_r  <= '0;
            cnt     <= '0;
            idle    <= '0;
            valid_r <= 1'b0;
            ovr     <= 1'b0;
            ferr    <= 1'b0;
        end else begin
            state   <= state_n;
            shreg   <= shreg_n;
            pout_r  <= pout_n;
            cnt     <= cnt_n;
            idle    <= idle_n;
            valid_r <= valid_n;
            ovr     <= ovr_n;
            ferr    <= ferr_n;
        end
    end

    always_comb begin
        state_n = state;
        shreg_n = shreg;
        cnt_n   = cnt;
        idle_n  = idle;
        pout_n  = pout_r;
        valid_n = valid_r;
        ovr_n   = ovr & ~bus.clr;
        ferr_n  = ferr & ~bus.clr;
        done    = 1'b0;

        unique case (state)
            IDLE: begin
                if (bus.shift) begin
                    shreg_n = word;
                    cnt_n   = CW'(1);
                    idle_n  = '0;
                    state_n = SHIFT;
                end
            end
            SHIFT: begin
                if (bus.shift) begin
                    shreg_n = word;
                    idle_n  = '0;
                    if (cnt == CW'(WIDTH - 1)) begin
                        done    = 1'b1;
                        cnt_n   = '0;
                        state_n = IDLE;
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end else if (idle == 8'(TIMEOUT - 1)) begin
                    ferr_n  = 1'b1;
                    shreg_n = '0;
                    cnt_n   = '0;
                    idle_n  = '0;
                    state_n = IDLE;
                end else begin
                    idle_n = idle + 8'd1;
                end
            end
            default: ;
        endcase

        // a completing word may replace the one being acked this edge
        if (done && (!valid_r || bus.ack)) begin
            pout_n  = word;
            valid_n = 1'b1;
        end else if (done) begin
            ovr_n = 1'b1;
        end else if (bus.ack) begin
            valid_n = 1'b0;
        end
    end

    assign bus.pout      = pout_r;
    assign bus.valid     = valid_r;
    assign bus.busy      = (state == SHIFT);
    assign bus.bitcnt    = cnt;
    assign bus.overrun   = ovr;
    assign bus.frame_err = ferr;
endmodule

// File: tb/tb_sipo_deframer.sv
// Bench for sipo_deframer: directed scenarios plus random
// traffic checked against a queue-based frame model.
module tb_sipo_deframer;
    localparam int W  = 3;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad = 0;

    sipo_deframer_if #(.WIDTH(W)) bus ();

    sipo_deframer #(.WIDTH(W), .TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int         mq[$];
    int         m_idle = 0;
    logic [2:0] m_pout = '0;
    logic       m_valid = 1'b0;
    logic       m_ovr = 1'b0;
    logic       m_ferr = 1'b0;

    task automatic model_edge(input logic r, input logic sh,
                              input logic s, input logic a,
                              input logic c);
        bit done = 0;
        bit fset = 0;
        int w = 0;
        if (!r) begin
            mq.delete();
            m_idle = 0;
            m_pout = '0;
            m_valid = 1'b0;
            m_ovr = 1'b0;
            m_ferr = 1'b0;
            return;
        end
        if (sh) begin
            mq.push_back(int'(s));
            m_idle = 0;
            if (mq.size() == W) begin
                for (int i = 0; i < W; i++) w += mq[i] << i;
                mq.delete();
                done = 1;
            end
        end else if (mq.size() > 0) begin
            m_idle++;
            if (m_idle == TO) begin
                fset = 1;
                mq.delete();
                m_idle = 0;
            end
        end
        if (c) begin
            m_ovr = 1'b0;
            m_ferr = 1'b0;
        end
        if (fset) m_ferr = 1'b1;
        if (done) begin
            if (m_valid && !a) m_ovr = 1'b1;
            else begin
                m_pout = 3'(w);
                m_valid = 1'b1;
            end
        end else if (a) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic step(input logic sh, input logic s,
                        input logic a, input logic c,
                        input logic r);
        @(negedge clk);
        rst = r;
        bus.shift = sh;
        bus.si = s;
        bus.ack = a;
        bus.clr = c;
        @(posedge clk);
        model_edge(r, sh, s, a, c);
        #1;
    endtask

    task automatic send(input logic b, input logic a, input logic c);
        step(1'b1, b, a, c, 1'b1);
    endtask

    task automatic idle_n(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'($urandom), 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_reset();
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        total++;
        if ({bus.pout, bus.valid, bus.busy, bus.bitcnt,
             bus.overrun, bus.frame_err} !== 10'b0) begin
            bad++;
            $display("FAIL reset: got pout=%b v=%b busy=%b cnt=%0d ovr=%b ferr=%b want all 0",
                     bus.pout, bus.valid, bus.busy, bus.bitcnt, bus.overrun, bus.frame_err);
        end
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_single();
        send(1, 0, 0); send(0, 0, 0); send(1, 0, 0);
        total++;
        if ({bus.pout, bus.valid, bus.busy, bus.overrun} !== 6'b101_1_0_0) begin
            bad++;
            $display("FAIL single: got pout=%b v=%b busy=%b ovr=%b want 101 1 0 0",
                     bus.pout, bus.valid, bus.busy, bus.overrun);
        end
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        total++;
        if ({bus.pout, bus.valid} !== 4'b101_0) begin
            bad++;
            $display("FAIL single_ack: got pout=%b v=%b want 101 0", bus.pout, bus.valid);
        end
    endtask

    task automatic test_back_to_back();
        send(1, 0, 0); send(0, 0, 0); send(0, 0, 0);
        total++;
        if ({bus.pout, bus.valid} !== 4'b001_1) begin
            bad++;
            $display("FAIL b2b_first: got pout=%b v=%b want 001 1", bus.pout, bus.valid);
        end
        send(0, 0, 0); send(1, 0, 0); send(1, 1, 0);
        total++;
        if ({bus.pout, bus.valid, bus.overrun} !== 5'b110_1_0) begin
            bad++;
            $display("FAIL b2b_second: got pout=%b v=%b ovr=%b want 110 1 0",
                     bus.pout, bus.valid, bus.overrun);
        end
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    endtask

    task automatic test_overrun();
        send(0, 0, 0); send(1, 0, 0); send(0, 0, 0);
        send(1, 0, 0); send(1, 0, 0); send(1, 0, 0);
        total++;
        if ({bus.pout, bus.valid, bus.overrun} !== 5'b010_1_1) begin
            bad++;
            $display("FAIL overrun: got pout=%b v=%b ovr=%b want 010 1 1",
                     bus.pout, bus.valid, bus.overrun);
        end
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        total++;
        if (bus.overrun !== 1'b0) begin
            bad++;
            $display("FAIL overrun_clr: got ovr=%b want 0", bus.overrun);
        end
        send(1, 0, 0); send(1, 0, 0); send(1, 0, 1);
        total++;
        if ({bus.pout, bus.overrun} !== 4'b010_1) begin
            bad++;
            $display("FAIL overrun_setwins: got pout=%b ovr=%b want 010 1",
                     bus.pout, bus.overrun);
        end
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    endtask

    task automatic test_timeout();
        send(1, 0, 0); send(1, 0, 0);
        idle_n(TO - 1);
        total++;
        if ({bus.busy, bus.bitcnt} !== 4'b1_010) begin
            bad++;
            $display("FAIL pause_hold: got busy=%b cnt=%0d want 1 2", bus.busy, bus.bitcnt);
        end
        send(0, 0, 0);
        total++;
        if ({bus.pout, bus.valid, bus.frame_err} !== 5'b011_1_0) begin
            bad++;
            $display("FAIL pause_word: got pout=%b v=%b ferr=%b want 011 1 0",
                     bus.pout, bus.valid, bus.frame_err);
        end
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        send(1, 0, 0); send(0, 0, 0);
        idle_n(TO);
        total++;
        if ({bus.frame_err, bus.bitcnt, bus.busy, bus.valid} !== 6'b1_000_0_0) begin
            bad++;
            $display("FAIL timeout: got ferr=%b cnt=%0d busy=%b v=%b want 1 0 0 0",
                     bus.frame_err, bus.bitcnt, bus.busy, bus.valid);
        end
        send(0, 0, 0); send(0, 0, 0); send(1, 0, 0);
        total++;
        if ({bus.pout, bus.valid} !== 4'b100_1) begin
            bad++;
            $display("FAIL after_timeout: got pout=%b v=%b want 100 1", bus.pout, bus.valid);
        end
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        total++;
        if (bus.frame_err !== 1'b0) begin
            bad++;
            $display("FAIL ferr_clr: got ferr=%b want 0", bus.frame_err);
        end
    endtask

    task automatic test_reset_midframe();
        send(1, 0, 0); send(0, 0, 0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        total++;
        if ({bus.bitcnt, bus.busy, bus.valid} !== 5'b000_0_0) begin
            bad++;
            $display("FAIL rst_mid: got cnt=%0d busy=%b v=%b want 0 0 0",
                     bus.bitcnt, bus.busy, bus.valid);
        end
        send(1, 0, 0); send(1, 0, 0); send(0, 0, 0);
        total++;
        if ({bus.pout, bus.valid} !== 4'b011_1) begin
            bad++;
            $display("FAIL rst_mid_word: got pout=%b v=%b want 011 1", bus.pout, bus.valid);
        end
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    endtask

    task automatic test_piso();
        logic [2:0] p = 3'b101;
        for (int i = 0; i < 3; i++) begin
            send(p[0], 0, 0);
            p = p >> 1;
        end
        total++;
        if ({bus.pout, bus.valid} !== 4'b101_1) begin
            bad++;
            $display("FAIL piso: got pout=%b v=%b want 101 1", bus.pout, bus.valid);
        end
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    endtask

    task automatic test_random();
        logic [9:0] exp;
        logic [9:0] got;
        int errs = 0;
        for (int n = 0; n < 600; n++) begin
            if ($urandom % 40 == 0) begin
                for (int k = 0; k < int'($urandom_range(10, 6)); k++)
                    step(1'b0, 1'($urandom), 1'($urandom % 3 == 0), 1'b0, 1'b1);
            end else begin
                step(1'($urandom % 8 < 5), 1'($urandom),
                     1'($urandom % 3 == 0), 1'($urandom % 16 == 0),
                     1'($urandom % 64 != 0));
            end
            exp = {m_pout, m_valid, 1'(mq.size() > 0), 3'(mq.size()), m_ovr, m_ferr};
            got = {bus.pout, bus.valid, bus.busy, bus.bitcnt, bus.overrun, bus.frame_err};
            total++;
            if (got !== exp) begin
                bad++;
                if (errs++ < 10)
                    $display("FAIL random[%0d]: got {pout,v,busy,cnt,ovr,ferr}=%b want %b",
                             n, got, exp);
            end
        end
    endtask

    initial begin
        bus.shift = 1'b0;
        bus.si = 1'b0;
        bus.ack = 1'b0;
        bus.clr = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_overrun();
        test_timeout();
        test_reset_midframe();
        test_piso();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
